// File: rtl/adder_seq_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
//   state_t : controller state encoding (IDLE, RUN, DONE)
//   BYTE_W  : width of the shared arithmetic slice in bits
package adder_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage : adder_seq_pkg

// File: rtl/adder_mp_sequencer_if.sv
// Command / result handshake bundle for adder_mp_sequencer.
//   start_valid/start_ready : command handshake (op_a, op_b, op_sub, op_cin)
//   res_valid/res_ready     : result handshake (result, res_cout, res_ovf)
// modport master : command source and result consumer
// modport slave  : the sequencer
interface adder_mp_sequencer_if
    import adder_seq_pkg::*;
#(
    parameter int NBYTES = 4
);
    localparam int W = NBYTES * BYTE_W;

    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_sub;
    logic         op_cin;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] result;
    logic         res_cout;
    logic         res_ovf;

    modport master (
        output start_valid, op_a, op_b, op_sub, op_cin, res_ready,
        input  start_ready, res_valid, result, res_cout, res_ovf
    );

    modport slave (
        input  start_valid, op_a, op_b, op_sub, op_cin, res_ready,
        output start_ready, res_valid, result, res_cout, res_ovf
    );

endinterface : adder_mp_sequencer_if

// File: rtl/adder_mp_sequencer_adder_8bits.sv
// adder_8bits: combinational 8-bit ripple-carry slice.
//   a, b : operand bytes
//   cin  : carry into bit 0
//   sum  : sum byte
//   cout : carry out of every bit; cout[7] is the byte carry, cout[6] is the
//          carry into the sign bit (used for signed overflow on the top byte)
module adder_8bits
    import adder_seq_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic [BYTE_W-1:0] cout
);

    logic [BYTE_W:0] carry_s;

    assign carry_s[0] = cin;

    for (genvar i = 0; i < BYTE_W; i++) begin : g_bit
        assign sum[i]         = a[i] ^ b[i] ^ carry_s[i];
        assign carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end

    assign cout = carry_s[BYTE_W:1];

endmodule : adder_8bits

// File: rtl/adder_mp_sequencer.sv
// adder_mp_sequencer: W-bit add/subtract performed one byte per cycle on a
// single shared adder_8bits slice, LSB byte first, with the carry registered
// between bytes.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of adder_mp_sequencer_if (command in, result out)
// Latency from command accept to res_valid is NBYTES cycles.
module adder_mp_sequencer
    import adder_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    adder_mp_sequencer_if.slave bus
);

    localparam int W     = NBYTES * BYTE_W;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t             state_r;
    state_t             state_next_s;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic [W-1:0]       result_r;
    logic [IDX_W-1:0]   idx_r;
    logic               carry_r;
    logic               cout_r;
    logic               ovf_r;
    logic               start_ready_r;
    logic               res_valid_r;
    logic               accept_s;
    logic               last_s;
    logic [BYTE_W-1:0]  a_byte_s;
    logic [BYTE_W-1:0]  b_byte_s;
    logic [BYTE_W-1:0]  sum_s;
    logic [BYTE_W-1:0]  cout_s;
    logic               unused_carry_s;

    // start_ready_r mirrors (state_r == IDLE), so this is the IDLE accept
    assign accept_s = bus.start_valid && start_ready_r;
    assign last_s   = (idx_r == LAST_IDX);

    assign a_byte_s = a_r[idx_r * BYTE_W +: BYTE_W];
    assign b_byte_s = b_r[idx_r * BYTE_W +: BYTE_W];

    // Only the byte carry and the carry into the sign bit are consumed here
    assign unused_carry_s = ^cout_s[BYTE_W-3:0];

    adder_8bits u_slice (
        .a    (a_byte_s),
        .b    (b_byte_s),
        .cin  (carry_r),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // Controller next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register plus handshake flags decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            start_ready_r <= 1'b1;
            res_valid_r   <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            start_ready_r <= (state_next_s == IDLE);
            res_valid_r   <= (state_next_s == DONE);
        end
    end

    // Operand capture and byte-serial accumulation of the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            result_r <= '0;
            idx_r    <= '0;
            carry_r  <= 1'b0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else if (accept_s) begin
            a_r     <= bus.op_a;
            // a - b - borrow == a + ~b + ~borrow
            b_r     <= bus.op_sub ? ~bus.op_b : bus.op_b;
            carry_r <= bus.op_cin ^ bus.op_sub;
            idx_r   <= '0;
        end else if (state_r == RUN) begin
            result_r[idx_r * BYTE_W +: BYTE_W] <= sum_s;
            carry_r <= cout_s[BYTE_W-1];
            idx_r   <= idx_r + IDX_W'(1);
            if (last_s) begin
                cout_r <= cout_s[BYTE_W-1];
                ovf_r  <= cout_s[BYTE_W-1] ^ cout_s[BYTE_W-2];
            end
        end
    end

    assign bus.start_ready = start_ready_r;
    assign bus.res_valid   = res_valid_r;
    assign bus.result      = result_r;
    assign bus.res_cout    = cout_r;
    assign bus.res_ovf     = ovf_r;

endmodule : adder_mp_sequencer
